// File: rtl/mmio_bus_decoder.sv
// -----------------------------------------------------------------------------
// mmio_bus_decoder
//
// Memory-mapped interconnect between the CPU data port and N_SLAVES peripheral
// slaves. Each access is matched against per-slave base/mask windows. The
// lowest matching index wins, so the slave select is always one-hot or zero.
// Read data is captured after the hit slave's read latency and returned as a
// registered response with a one-cycle ready pulse. Accesses that match no
// window complete in one cycle with err_o set. For reads, they also return
// ERR_DATA. The offending address is logged and a saturating error counter is
// incremented.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   req_i        CPU request; held with we_i/addr_i/wdata_i until ready_o
//   we_i         1 = write, 0 = read
//   addr_i       access address
//   wdata_i      write data
//   rdata_o      registered read data, held until the next read response
//   ready_o      one-cycle response pulse
//   err_o        unmapped-access flag, valid while ready_o = 1
//   sel_o        one-hot slave select
//   we_o         single-cycle write strobe to the selected slave
//   addr_o       address forwarded to slaves (combinational copy)
//   wdata_o      write data forwarded to slaves (combinational copy)
//   slv_rdata_i  packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   err_count_o  saturating count of unmapped accesses
//   err_addr_o   address of the most recent unmapped access
//
// ERR_CNT_MAX sets the saturation value of the error counter. Leave it at
// 16'hFFFF for the full counter range.
// -----------------------------------------------------------------------------
module mmio_bus_decoder #(
   parameter int                         N_SLAVES    = 4,
   parameter int                         DATA_W      = 32,
   parameter int                         ADDR_W      = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE    = {32'h0004_0000, 32'h0000_2020,
                                                        32'h0000_2010, 32'h0000_2000},
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK    = {32'hFFFC_0000, 32'hFFFF_FFF0,
                                                        32'hFFFF_FFF0, 32'hFFFF_FFF0},
   parameter logic [N_SLAVES*2-1:0]      SLV_LAT     = {2'd1, 2'd0, 2'd0, 2'd0},
   parameter logic [DATA_W-1:0]          ERR_DATA    = 32'hDEAD_BEEF,
   parameter logic [15:0]                ERR_CNT_MAX = 16'hFFFF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [ADDR_W-1:0]          addr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   output logic [DATA_W-1:0]          rdata_o,
   output logic                       ready_o,
   output logic                       err_o,
   output logic [N_SLAVES-1:0]        sel_o,
   output logic                       we_o,
   output logic [ADDR_W-1:0]          addr_o,
   output logic [DATA_W-1:0]          wdata_o,
   input  logic [N_SLAVES*DATA_W-1:0] slv_rdata_i,
   output logic [15:0]                err_count_o,
   output logic [ADDR_W-1:0]          err_addr_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Reduce a raw match vector to one-hot. The lowest index has priority.
   function automatic logic [N_SLAVES-1:0] prio_onehot(input logic [N_SLAVES-1:0] m);
      logic [N_SLAVES-1:0] r;
      r = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (m[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // Read latency of the slave picked by a one-hot (or zero) select.
   function automatic logic [1:0] lat_of(input logic [N_SLAVES-1:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (oh[i]) r = r | SLV_LAT[i*2 +: 2];
      end
      return r;
   endfunction

   // AND-OR read-data mux driven by a one-hot select.
   function automatic logic [DATA_W-1:0] rdata_mux(input logic [N_SLAVES-1:0]        oh,
                                                   input logic [N_SLAVES*DATA_W-1:0] bus);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (oh[i]) r = r | bus[i*DATA_W +: DATA_W];
      end
      return r;
   endfunction

   // Saturating increment of the unmapped-access counter.
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c >= ERR_CNT_MAX) ? c : c + 16'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t              state_q,     state_d;
   logic [1:0]          cnt_q,       cnt_d;
   logic [N_SLAVES-1:0] lat_sel_q,   lat_sel_d;   // slave being waited on in WAIT
   logic [DATA_W-1:0]   rdata_q,     rdata_d;
   logic                ready_q,     ready_d;
   logic                err_q,       err_d;
   logic [15:0]         err_cnt_q,   err_cnt_d;
   logic [ADDR_W-1:0]   err_addr_q,  err_addr_d;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [N_SLAVES-1:0] match;
   logic [N_SLAVES-1:0] hit;
   logic                any_hit;
   logic [1:0]          hit_lat;
   logic                accept;

   always_comb begin
      match = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         match[i] = ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
      end
   end

   assign hit     = prio_onehot(match);
   assign any_hit = |hit;
   assign hit_lat = lat_of(hit);
   assign accept  = (state_q == ST_IDLE) && req_i;

   // The select follows the live decode while the access is outstanding. The
   // master holds addr_i stable, so the select stays constant through WAIT.
   assign sel_o   = (accept || (state_q == ST_WAIT)) ? hit : '0;
   assign we_o    = accept && we_i && any_hit;
   assign addr_o  = addr_i;
   assign wdata_o = wdata_i;

   // ---------------------------------------------------------------------------
   // FSM next state and response datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_sel_d  = lat_sel_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               if (!any_hit) begin
                  state_d    = ST_RESP;
                  ready_d    = 1'b1;
                  err_d      = 1'b1;
                  err_addr_d = addr_i;
                  err_cnt_d  = sat_inc(err_cnt_q);
                  if (!we_i) rdata_d = ERR_DATA;
               end else if (we_i) begin
                  // Writes complete without waiting for the slave's read latency.
                  state_d = ST_RESP;
                  ready_d = 1'b1;
               end else if (hit_lat == 2'd0) begin
                  rdata_d = rdata_mux(hit, slv_rdata_i);
                  state_d = ST_RESP;
                  ready_d = 1'b1;
               end else begin
                  // The counter holds the number of extra WAIT cycles still to
                  // go. Data is captured when it reaches zero.
                  state_d   = ST_WAIT;
                  cnt_d     = hit_lat - 2'd1;
                  lat_sel_d = hit;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               rdata_d = rdata_mux(lat_sel_q, slv_rdata_i);
               state_d = ST_RESP;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            // req_i is not sampled here, so each access takes at least two cycles.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and response registers. Reset drops any in-flight access.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lat_sel_q  <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_sel_q  <= lat_sel_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign ready_o     = ready_q;
   assign err_o       = err_q;
   assign err_count_o = err_cnt_q;
   assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// -----------------------------------------------------------------------------
// tb_mmio_bus_decoder
//
// Self-checking bench for mmio_bus_decoder.
//
// u_dut uses the default address map. u_alt has slaves 1 and 2 both covering
// 0x2010 and an error counter that saturates at 5.
//
// Slave i always presents (base + i) on its read port, so the read value
// identifies which slave's data was captured.
// -----------------------------------------------------------------------------
module tb_mmio_bus_decoder;

   logic          clk;
   logic          reset;
   logic          req;
   logic          we;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [127:0]  slv_rdata;

   logic [31:0]   rdata_o,   a_rdata_o;
   logic          ready_o,   a_ready_o;
   logic          err_o,     a_err_o;
   logic [3:0]    sel_o,     a_sel_o;
   logic          we_o,      a_we_o;
   logic [31:0]   addr_o,    a_addr_o;
   logic [31:0]   wdata_o,   a_wdata_o;
   logic [15:0]   cnt_o,     a_cnt_o;
   logic [31:0]   eaddr_o,   a_eaddr_o;

   int total = 0;
   int bad   = 0;

   mmio_bus_decoder u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rdata_o     (rdata_o),
      .ready_o     (ready_o),
      .err_o       (err_o),
      .sel_o       (sel_o),
      .we_o        (we_o),
      .addr_o      (addr_o),
      .wdata_o     (wdata_o),
      .slv_rdata_i (slv_rdata),
      .err_count_o (cnt_o),
      .err_addr_o  (eaddr_o)
   );

   mmio_bus_decoder #(
      .SLV_BASE    ({32'h0004_0000, 32'h0000_2010, 32'h0000_2010, 32'h0000_2000}),
      .ERR_CNT_MAX (16'd5)
   ) u_alt (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rdata_o     (a_rdata_o),
      .ready_o     (a_ready_o),
      .err_o       (a_err_o),
      .sel_o       (a_sel_o),
      .we_o        (a_we_o),
      .addr_o      (a_addr_o),
      .wdata_o     (a_wdata_o),
      .slv_rdata_i (slv_rdata),
      .err_count_o (a_cnt_o),
      .err_addr_o  (a_eaddr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] sdata;      // slave base data while selected
      logic [31:0] sdata2;     // slave base data from the cycle after select
      logic [3:0]  exp_sel;
      int          exp_we;     // number of write strobes expected
      int          exp_lat;    // cycles from acceptance edge to ready
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [15:0] exp_cnt;
      logic [31:0] exp_eaddr;
   } vec_t;

   vec_t vecs[12];
   vec_t sb[$];

   function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] sd, input logic [31:0] sd2,
                                input logic [3:0] s, input int nwe, input int lat,
                                input logic e, input logic [31:0] rd,
                                input logic [15:0] c, input logic [31:0] ea);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = wd; v.sdata = sd; v.sdata2 = sd2;
      v.exp_sel = s; v.exp_we = nwe; v.exp_lat = lat; v.exp_err = e;
      v.exp_rdata = rd; v.exp_cnt = c; v.exp_eaddr = ea;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_slaves(input logic [31:0] base);
      for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = base + 32'(i);
   endtask

   // Drives one access at a falling edge and waits (bounded) for its response.
   task automatic run_access(input vec_t v);
      int   n;
      int   wes;
      logic got;
      vec_t e;
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
      set_slaves(v.sdata);
      sb.push_back(v);
      #1;
      chk("sel_t", 32'(sel_o), 32'(v.exp_sel));
      chk("addr_pass", addr_o, v.addr);
      chk("wdata_pass", wdata_o, v.wdata);
      wes = int'(we_o);
      n   = 0;
      got = 1'b0;
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         wes += int'(we_o);
         if (ready_o) got = 1'b1;
         else begin
            chk("sel_wait", 32'(sel_o), 32'(v.exp_sel));
            if (n == 1) set_slaves(v.sdata2);
         end
      end
      e = sb.pop_front();
      chk("latency", 32'(n), 32'(e.exp_lat));
      chk("err", 32'(err_o), 32'(e.exp_err));
      chk("rdata", rdata_o, e.exp_rdata);
      chk("err_count", 32'(cnt_o), 32'(e.exp_cnt));
      chk("err_addr", eaddr_o, e.exp_eaddr);
      chk("sel_resp", 32'(sel_o), 32'd0);
      chk("we_strobes", 32'(wes), 32'(e.exp_we));
      req = 1'b0;
      @(negedge clk);
      chk("ready_pulse", 32'(ready_o), 32'd0);
   endtask

   initial begin
      int   pulses;
      int   errp;
      int   idx;
      vec_t v;

      //                we    addr            wdata        sdata        sdata2       sel      nwe lat err rdata          cnt    eaddr
      vecs[0]  = mkv(1'b0, 32'h0000_2000, 32'h0,       32'h0000_A5A5, 32'h0000_A5A5, 4'b0001, 0, 1, 1'b0, 32'h0000_A5A5, 16'd0, 32'h0);
      vecs[1]  = mkv(1'b0, 32'h0000_2024, 32'h0,       32'h0000_0100, 32'h0000_0100, 4'b0100, 0, 1, 1'b0, 32'h0000_0102, 16'd0, 32'h0);
      vecs[2]  = mkv(1'b0, 32'h0004_0010, 32'h0,       32'h0000_5000, 32'h0000_5000, 4'b1000, 0, 2, 1'b0, 32'h0000_5003, 16'd0, 32'h0);
      vecs[3]  = mkv(1'b1, 32'h0000_2014, 32'h0000_CAFE, 32'h0,       32'h0,         4'b0010, 1, 1, 1'b0, 32'h0000_5003, 16'd0, 32'h0);
      vecs[4]  = mkv(1'b0, 32'h0000_3000, 32'h0,       32'h0,         32'h0,         4'b0000, 0, 1, 1'b1, 32'hDEAD_BEEF, 16'd1, 32'h0000_3000);
      vecs[5]  = mkv(1'b1, 32'h0008_0000, 32'h1234,    32'h0,         32'h0,         4'b0000, 0, 1, 1'b1, 32'hDEAD_BEEF, 16'd2, 32'h0008_0000);
      vecs[6]  = mkv(1'b0, 32'h0000_2010, 32'h0,       32'h0000_0077, 32'h0000_0077, 4'b0010, 0, 1, 1'b0, 32'h0000_0078, 16'd2, 32'h0008_0000);
      vecs[7]  = mkv(1'b0, 32'h0007_FFFC, 32'h0,       32'h0000_9000, 32'h0000_9000, 4'b1000, 0, 2, 1'b0, 32'h0000_9003, 16'd2, 32'h0008_0000);
      vecs[8]  = mkv(1'b0, 32'h0000_201F, 32'h0,       32'h0,         32'h0,         4'b0010, 0, 1, 1'b0, 32'h0000_0001, 16'd2, 32'h0008_0000);
      vecs[9]  = mkv(1'b0, 32'h0000_2030, 32'h0,       32'h0,         32'h0,         4'b0000, 0, 1, 1'b1, 32'hDEAD_BEEF, 16'd3, 32'h0000_2030);
      vecs[10] = mkv(1'b1, 32'h0000_2000, 32'h0000_0001, 32'h0,       32'h0,         4'b0001, 1, 1, 1'b0, 32'hDEAD_BEEF, 16'd3, 32'h0000_2030);
      vecs[11] = mkv(1'b0, 32'h0003_FFFC, 32'h0,       32'h0,         32'h0,         4'b0000, 0, 1, 1'b1, 32'hDEAD_BEEF, 16'd4, 32'h0003_FFFC);

      reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      slv_rdata = '0;

      // Reset state
      #12;
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_cnt", 32'(cnt_o), 32'd0);
      chk("rst_eaddr", eaddr_o, 32'd0);
      chk("rst_sel", 32'(sel_o), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Table-driven accesses
      for (int i = 0; i < 12; i++) run_access(vecs[i]);

      // RAM read: slave 3 data changes in the cycle after select and the
      // later value must be the one captured.
      run_access(mkv(1'b0, 32'h0004_0010, 32'h0, 32'h1111_110E, 32'h1234_5675, 4'b1000, 0, 2,
                     1'b0, 32'h1234_5678, 16'd4, 32'h0003_FFFC));

      // Reset while WAITing on a RAM read drops the access
      req = 1'b1; we = 1'b0; addr = 32'h0004_0010; set_slaves(32'h0);
      #1 chk("b_sel_t", 32'(sel_o), 32'b1000);
      @(negedge clk);
      chk("b_sel_wait", 32'(sel_o), 32'b1000);
      chk("b_ready_wait", 32'(ready_o), 32'd0);
      reset = 1'b0; req = 1'b0;
      #1;
      chk("b_ready", 32'(ready_o), 32'd0);
      chk("b_err", 32'(err_o), 32'd0);
      chk("b_rdata", rdata_o, 32'd0);
      chk("b_cnt", 32'(cnt_o), 32'd0);
      chk("b_eaddr", eaddr_o, 32'd0);
      chk("b_sel", 32'(sel_o), 32'd0);
      chk("b_we", 32'(we_o), 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("b_ready_in_rst", 32'(ready_o), 32'd0);
      end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("b_ready_after_rst", 32'(ready_o), 32'd0);
      end
      run_access(mkv(1'b0, 32'h0000_2000, 32'h0, 32'h0000_4242, 32'h0000_4242, 4'b0001, 0, 1,
                     1'b0, 32'h0000_4242, 16'd0, 32'h0));

      // Overlapping windows: lowest index wins
      req = 1'b1; we = 1'b0; addr = 32'h0000_2010; wdata = 32'h0000_00AB; set_slaves(32'h10);
      #1;
      chk("ovl_sel", 32'(a_sel_o), 32'b0010);
      chk("ovl_main_sel", 32'(sel_o), 32'b0010);
      chk("ovl_we", 32'(a_we_o), 32'd0);
      chk("ovl_addr_pass", a_addr_o, 32'h0000_2010);
      chk("ovl_wdata_pass", a_wdata_o, 32'h0000_00AB);
      @(negedge clk);
      chk("ovl_ready", 32'(a_ready_o), 32'd1);
      chk("ovl_err", 32'(a_err_o), 32'd0);
      chk("ovl_rdata", a_rdata_o, 32'h11);
      chk("ovl_main_rdata", rdata_o, 32'h11);
      req = 1'b0;
      @(negedge clk);

      // Error counter: counts from zero after reset; u_alt saturates at 5
      for (int k = 0; k < 7; k++) begin
         v = mkv(1'b0, 32'h0000_5000 + 32'(k) * 4, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 1,
                 1'b1, 32'hDEAD_BEEF, 16'(k + 1), 32'h0000_5000 + 32'(k) * 4);
         run_access(v);
         chk("alt_sat", 32'(a_cnt_o), (k + 1 < 5) ? 32'(k + 1) : 32'd5);
      end

      // Back-to-back unmapped reads with req held: one response every 2 cycles
      pulses = 0; errp = 0; idx = 0;
      req = 1'b1; we = 1'b0; addr = 32'h0000_6000;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (ready_o) begin
            pulses++;
            if (err_o && rdata_o == 32'hDEAD_BEEF) errp++;
            idx++;
            addr = 32'h0000_6000 + 32'(idx) * 4;
         end
         if (c == 600) req = 1'b0;
      end
      @(negedge clk);
      chk("b2b_pulses", 32'(pulses), 32'd300);
      chk("b2b_err_pulses", 32'(errp), 32'd300);
      chk("b2b_cnt", 32'(cnt_o), 32'd307);
      chk("b2b_eaddr", eaddr_o, 32'h0000_64AC);
      chk("b2b_alt_cnt", 32'(a_cnt_o), 32'd5);
      chk("b2b_alt_eaddr", a_eaddr_o, 32'h0000_64AC);
      chk("b2b_idle_ready", 32'(ready_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_bus_decoder.md
Name: mmio_bus_decoder

Overview:
Parametrised memory-mapped interconnect between the CPU data port and N peripheral slaves (switches/buttons, UARTs, RAM, LEDs, ...). It decodes each CPU access against per-slave base/mask windows and drives one-hot slave selects. It collects read data per slave according to that slave's read latency, and returns a registered response with a ready/error handshake. Unmapped accesses are caught, logged and answered with a fixed error word; read data is never left unassigned.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
DATA_W, 32, data width
ADDR_W, 32, address width
SLV_BASE, {32'h0004_0000, 32'h0000_2020, 32'h0000_2010, 32'h0000_2000}, packed N_SLAVES*ADDR_W base addresses; slave i is at bits [i*ADDR_W +: ADDR_W]
SLV_MASK, {32'hFFFC_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0}, packed compare masks
SLV_LAT, {2'd1, 2'd0, 2'd0, 2'd0}, packed 2-bit read latency per slave (0..3 cycles)
ERR_DATA, 32'hDEAD_BEEF, read data returned on an unmapped access

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_i  in  1  CPU access request; held, together with its qualifiers, until ready_o
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_W  access address
wdata_i  in  DATA_W  write data
rdata_o  out  DATA_W  registered read data
ready_o  out  1  one-cycle response pulse
err_o  out  1  unmapped-access flag, valid while ready_o = 1
sel_o  out  N_SLAVES  one-hot slave select
we_o  out  1  write strobe to slaves
addr_o  out  ADDR_W  address forwarded to slaves (copy of addr_i)
wdata_o  out  DATA_W  write data forwarded to slaves (copy of wdata_i)
slv_rdata_i  in  N_SLAVES*DATA_W  packed slave read data
err_count_o  out  16  saturating count of unmapped accesses
err_addr_o  out  ADDR_W  address of the last unmapped access

Behaviour:
- Match rule: slave i is hit when (addr_i & MASK_i) == BASE_i. On multiple hits the lowest index wins; the result is one-hot or all-zero.
- FSM states: IDLE, WAIT, RESP.
- Acceptance: the edge at which the FSM is in IDLE and req_i = 1 is cycle t.
- sel_o = hit vector while (IDLE && req_i) or WAIT; otherwise 0.
- we_o = we_i && any hit && IDLE && req_i. This gives exactly one write strobe, in cycle t only.
- Write, mapped: IDLE -> RESP. ready_o = 1 in cycle t+1 with err_o = 0; rdata_o is unchanged. Write responses never wait on SLV_LAT.
- Read, mapped, L = SLV_LAT of the hit slave:
  - L = 0: slv_rdata_i[hit] is captured at the edge ending cycle t; IDLE -> RESP.
  - L > 0: IDLE -> WAIT and a counter loads L-1. The counter decrements in WAIT. Data is captured on the edge where the counter reads 0; WAIT -> RESP.
  - ready_o is high in cycle t+1+L.
- Unmapped (read or write): no sel_o, no we_o; IDLE -> RESP.
  - In cycle t+1: ready_o = 1, err_o = 1.
  - For reads only, rdata_o = ERR_DATA.
  - err_addr_o <= addr_i; err_count_o increments and saturates at 16'hFFFF.
- RESP lasts one cycle, then returns to IDLE. req_i is ignored in RESP. Back-to-back requests are accepted in the cycle after ready_o, giving a minimum of 2 cycles per access.
- rdata_o holds its value until the next read response.
- addr_o and wdata_o are combinational pass-through.
- Reset (asynchronous, any state including WAIT): FSM goes to IDLE.
  - rdata_o = 0, ready_o = 0, err_o = 0, err_count_o = 0, err_addr_o = 0.
  - Any in-flight access is dropped with no response.
- req_i falling before ready_o is a master protocol violation. Behaviour in that case is undefined, but the FSM must still return to IDLE within 1+3 cycles.

Test Plan:
- Read 0x2000 with slave0 data 0x0000_A5A5 -> sel_o = 4'b0001 in cycle t; ready_o in t+1; rdata_o = 0x0000_A5A5; err_o = 0.
- Read 0x0004_0010 (RAM, L = 1); slave3 data changes from 0x1111_1111 to 0x1234_5678 one cycle after select -> ready_o in t+2; rdata_o = 0x1234_5678; sel_o = 4'b1000 held for 2 cycles.
- Write 0x2014 with data 0xCAFE -> we_o high for exactly 1 cycle with sel_o = 4'b0010; wdata_o = 0xCAFE; ready_o in t+1; no second strobe.
- Read 0x3000 (unmapped) -> sel_o = 0; ready_o = err_o = 1 in t+1; rdata_o = 0xDEAD_BEEF; err_addr_o = 0x3000; err_count_o = 1. Then 65536 more unmapped accesses -> err_count_o = 0xFFFF.
- Overlapping windows (override SLV_BASE so slaves 1 and 2 both cover 0x2010) -> sel_o = 4'b0010.
- reset low while in WAIT on a RAM read -> ready_o never pulses; all outputs 0. After release, a read of 0x2000 completes normally in 2 cycles.
